// File: rtl/mii_pkg.sv
// Shared definitions for the MII receive checker.
//   - Control character codes (idle / start / end-of-frame).
//   - Word-class enum produced by the classifier.
//   - Checker state enum.
package mii_pkg;

  localparam logic [7:0] IDLE_CODE  = 8'h07;
  localparam logic [7:0] START_CODE = 8'hFB;
  localparam logic [7:0] EOF_CODE   = 8'hFD;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    WC_IDLE,
    WC_START,
    WC_EOF,
    WC_DATA,
    WC_BAD
  } word_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_DROP
  } state_e;

endpackage

// File: rtl/mii_word_classifier.sv
// Combinational classifier for one received word.
// Ports:
//   i_data  - received word, byte 0 in bits [7:0]
//   i_ctrl  - one control flag per byte
//   o_class - IDLE / START / EOF / DATA / BAD
// START carries the start code in byte 0, EOF carries the end code in the
// last byte; every other byte of a control word must be the idle code.
module mii_word_classifier
  import mii_pkg::*;
#(
  parameter int         DATA_WIDTH = 64,
  parameter int         CTRL_WIDTH = 8,
  parameter logic [7:0] IDLE_CODE  = mii_pkg::IDLE_CODE,
  parameter logic [7:0] START_CODE = mii_pkg::START_CODE,
  parameter logic [7:0] EOF_CODE   = mii_pkg::EOF_CODE
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  output word_class_e           o_class
);

  logic [CTRL_WIDTH-1:0] byte_idle;
  logic                  first_start;
  logic                  last_eof;
  logic                  all_ctrl;
  logic                  no_ctrl;

  for (genvar k = 0; k < CTRL_WIDTH; k++) begin : g_byte
    assign byte_idle[k] = (i_data[8*k +: 8] == IDLE_CODE);
  end

  assign first_start = (i_data[7:0] == START_CODE);
  assign last_eof    = (i_data[8*(CTRL_WIDTH-1) +: 8] == EOF_CODE);
  assign all_ctrl    = &i_ctrl;
  assign no_ctrl     = ~|i_ctrl;

  always_comb begin
    o_class = WC_BAD;
    if (no_ctrl) begin
      o_class = WC_DATA;
    end else if (all_ctrl) begin
      if (&byte_idle)
        o_class = WC_IDLE;
      else if (first_start && (&byte_idle[CTRL_WIDTH-1:1]))
        o_class = WC_START;
      else if (last_eof && (&byte_idle[CTRL_WIDTH-2:0]))
        o_class = WC_EOF;
    end
  end

endmodule

// File: rtl/mii_rx_checker.sv
// MII receive frame checker.
// Tracks START / DATA... / EOF framing, checks every payload byte against
// DATA_BYTE and the payload length against [MIN_WORDS, MAX_WORDS], and
// keeps good/bad frame statistics.
// Ports:
//   clk, i_rst_n          - clock (rising edge), async active-low reset
//   i_rx_data, i_rx_ctrl  - one received word per cycle, no backpressure
//   o_frame_valid         - one-cycle pulse closing a frame
//   o_frame_ok/_len       - verdict and payload word count, held to next close
//   o_good_cnt/_bad_cnt   - wrapping frame counters
//   o_sync_err            - pulse for an illegal word outside a frame
//   o_busy                - high while inside a frame (PAYLOAD or DROP)
module mii_rx_checker
  import mii_pkg::*;
#(
  parameter int         DATA_WIDTH = 64,
  parameter int         CTRL_WIDTH = 8,
  parameter logic [7:0] IDLE_CODE  = mii_pkg::IDLE_CODE,
  parameter logic [7:0] START_CODE = mii_pkg::START_CODE,
  parameter logic [7:0] EOF_CODE   = mii_pkg::EOF_CODE,
  parameter logic [7:0] DATA_BYTE  = 8'hAA,
  parameter int         MIN_WORDS  = 1,
  parameter int         MAX_WORDS  = 16,
  parameter int         CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
  output logic                  o_frame_valid,
  output logic                  o_frame_ok,
  output logic [15:0]           o_frame_len,
  output logic [CNT_WIDTH-1:0]  o_good_cnt,
  output logic [CNT_WIDTH-1:0]  o_bad_cnt,
  output logic                  o_sync_err,
  output logic                  o_busy
);

  localparam logic [31:0] MIN_W = 32'(MIN_WORDS);
  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  word_class_e wclass;

  mii_word_classifier #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH),
    .IDLE_CODE  (IDLE_CODE),
    .START_CODE (START_CODE),
    .EOF_CODE   (EOF_CODE)
  ) u_cls (
    .i_data  (i_rx_data),
    .i_ctrl  (i_rx_ctrl),
    .o_class (wclass)
  );

  // Any payload byte differing from the expected pattern.
  logic data_mis;
  always_comb begin
    data_mis = 1'b0;
    for (int k = 0; k < CTRL_WIDTH; k++)
      if (i_rx_data[8*k +: 8] != DATA_BYTE) data_mis = 1'b1;
  end

  state_e         state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic           mis_q, mis_d;

  logic             fv_q, fok_q, serr_q;
  logic [LEN_W-1:0] flen_q;
  logic [CNT_WIDTH-1:0] good_q, bad_q;

  logic             close, close_ok, sync_d;
  logic [LEN_W-1:0] len_inc;
  logic             over_max, len_in_range;

  assign len_inc      = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + 16'd1;
  assign over_max     = (32'(len_inc) > MAX_W);
  assign len_in_range = (32'(len_q) >= MIN_W) && (32'(len_q) <= MAX_W);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    mis_d    = mis_q;
    close    = 1'b0;
    close_ok = 1'b0;
    sync_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        case (wclass)
          WC_IDLE: ;
          WC_START: begin
            len_d   = '0;
            mis_d   = 1'b0;
            state_d = ST_PAYLOAD;
          end
          default: sync_d = 1'b1;
        endcase
      end
      ST_PAYLOAD: begin
        case (wclass)
          WC_DATA: begin
            len_d = len_inc;
            if (data_mis) mis_d = 1'b1;
            // Oversize frames are already bad; the rest of the payload is
            // swallowed so the reported length stops at MAX_WORDS+1.
            if (over_max) state_d = ST_DROP;
          end
          WC_EOF: begin
            close    = 1'b1;
            close_ok = !mis_q && len_in_range;
            state_d  = ST_IDLE;
          end
          WC_START: begin
            // Close the truncated frame and open the new one in one cycle.
            close = 1'b1;
            len_d = '0;
            mis_d = 1'b0;
          end
          default: begin
            close   = 1'b1;
            state_d = ST_IDLE;
          end
        endcase
      end
      ST_DROP: begin
        case (wclass)
          WC_DATA: ;
          WC_START: begin
            close   = 1'b1;
            len_d   = '0;
            mis_d   = 1'b0;
            state_d = ST_PAYLOAD;
          end
          default: begin
            close   = 1'b1;
            state_d = ST_IDLE;
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      mis_q   <= 1'b0;
      fv_q    <= 1'b0;
      fok_q   <= 1'b0;
      flen_q  <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      mis_q   <= mis_d;
      fv_q    <= close;
      serr_q  <= sync_d;
      if (close) begin
        fok_q  <= close_ok;
        flen_q <= len_q;
        if (close_ok) good_q <= good_q + CNT_WIDTH'(1);
        else          bad_q  <= bad_q + CNT_WIDTH'(1);
      end
    end
  end

  assign o_frame_valid = fv_q;
  assign o_frame_ok    = fok_q;
  assign o_frame_len   = flen_q;
  assign o_good_cnt    = good_q;
  assign o_bad_cnt     = bad_q;
  assign o_sync_err    = serr_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule
